leaf_out_stream_buffer: RTL
===========================

LEAF_OUT_STREAM_BUFFER -- requirements
Module: leaf_out_stream_buffer

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32, width of one user data word.
REQ-002 SHALL have parameter DEPTH_BITS, default 4, log2 of buffer depth (16 entries).
REQ-003 SHALL have port clk_user, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port clear, input, 1, synchronous flush request, active-high.
REQ-006 SHALL have port din_user, input, PAYLOAD_BITS, data word from the user kernel output port.
REQ-007 SHALL have port vld_user, input, 1, din_user is valid.
REQ-008 SHALL have port ack_to_user, output, 1, buffer accepts a word this cycle.
REQ-009 SHALL have port din_leaf_user2interface, output, PAYLOAD_BITS, word presented to leaf_interface.
REQ-010 SHALL have port vld_user2interface, output, 1, din_leaf_user2interface is valid.
REQ-011 SHALL have port ack_interface2user, input, 1, leaf_interface consumed the presented word.
REQ-012 SHALL have port occupancy, output, DEPTH_BITS+1, current number of stored words.

Function
REQ-013 SHALL implement a circular FIFO of 2^DEPTH_BITS entries with a write pointer, a read pointer and a count register.
REQ-014 SHALL perform a push on every cycle where vld_user && ack_to_user is high.
REQ-015 SHALL perform a pop on every cycle where vld_user2interface && ack_interface2user is high.
REQ-016 SHALL drive ack_to_user = (count != 2^DEPTH_BITS), registered-state-only; no combinational path from ack_interface2user.
REQ-017 SHALL drive vld_user2interface = (count != 0) and din_leaf_user2interface = entry at the read pointer (first-word-fall-through).
REQ-018 SHALL make a pushed word visible on the downstream side one cycle after the push; there is no same-cycle bypass when empty.
REQ-019 SHALL hold din_leaf_user2interface stable while vld_user2interface is high and ack_interface2user is low.
REQ-020 SHALL, on a simultaneous push and pop, leave count unchanged and advance both pointers.
REQ-021 SHALL, when full, refuse pushes even if a pop occurs in the same cycle; ack_to_user rises on the following cycle.
REQ-022 SHALL wrap both pointers modulo 2^DEPTH_BITS.
REQ-023 SHALL ignore ack_interface2user when empty and vld_user when full; count never underflows or overflows.
REQ-024 SHALL, when clear is high, zero pointers and count next cycle; clear overrides any push or pop that cycle.
REQ-025 SHALL drive occupancy = count.
REQ-026 SHALL preserve word order exactly: words leave in push order, with no duplication or loss.

Reset
REQ-027 SHALL, while reset_n is low, asynchronously force pointers and count to 0, so vld_user2interface = 0, ack_to_user = 1, occupancy = 0.
REQ-028 SHALL not reset storage contents; din_leaf_user2interface is don't-care while vld_user2interface = 0.
REQ-029 SHALL discard all buffered words when reset_n asserts mid-operation; operation resumes on the first clock edge after deassertion.

Configuration
REQ-030 SHALL, with macro LEAF_OUT_BUF_STATS_EN defined, add outputs word_count (32 bits, increments per pop) and stall_count (32 bits, increments each cycle vld_user2interface && !ack_interface2user); both saturate at all-ones and reset to 0 on reset_n or clear.
REQ-031 SHALL, without LEAF_OUT_BUF_STATS_EN, omit both ports and counters entirely, with no other change in behaviour.

Verification
REQ-032 SHALL cover the fill test: ack_interface2user=0, push 0x00..0x0F over 16 cycles -> ack_to_user=0 after the 16th push, occupancy=16, and a 17th word 0xAA is not accepted.
REQ-033 SHALL cover the drain order test: after the fill test, hold ack_interface2user=1 -> outputs 0x00..0x0F on consecutive cycles, then vld_user2interface=0 and occupancy=0.
REQ-034 SHALL cover the latency test: empty buffer, push 0x1234 at cycle N -> vld_user2interface=1 with data 0x1234 at cycle N+1, not at N.
REQ-035 SHALL cover the full push/pop test: full buffer, vld_user=1 and ack_interface2user=1 in the same cycle -> one pop, push refused, occupancy=15, ack_to_user=1 the next cycle.
REQ-036 SHALL cover the clear/reset test: occupancy=5; pulse clear with a push -> occupancy=0 the next cycle; repeat with reset_n low -> immediate vld_user2interface=0, ack_to_user=1.
REQ-037 SHALL cover the stats test (LEAF_OUT_BUF_STATS_EN): 3 stall cycles then 4 pops -> stall_count=3, word_count=4.

Source files
------------

// File: rtl/leaf_out_stream_buffer.sv
// leaf_out_stream_buffer
// First-word-fall-through circular buffer between a user kernel output port
// and leaf_interface. A word pushed on one edge is visible downstream from the
// next cycle. The upstream ready depends only on registered fill state, so no
// combinational path runs from the downstream ack back to the user side.
// Optional build macro: LEAF_OUT_BUF_STATS_EN adds saturating word and stall
// counters on the word_count / stall_count outputs.
module leaf_out_stream_buffer #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4
) (
    input  logic                    clk_user,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic [PAYLOAD_BITS-1:0] din_user,
    input  logic                    vld_user,
    output logic                    ack_to_user,
    output logic [PAYLOAD_BITS-1:0] din_leaf_user2interface,
    output logic                    vld_user2interface,
    input  logic                    ack_interface2user,
    output logic [DEPTH_BITS:0]     occupancy
`ifdef LEAF_OUT_BUF_STATS_EN
    ,
    output logic [31:0]             word_count,
    output logic [31:0]             stall_count
`endif
);

    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] FULL_COUNT = (DEPTH_BITS+1)'(DEPTH);

    logic [PAYLOAD_BITS-1:0] r_mem [DEPTH];
    logic [DEPTH_BITS-1:0]   r_wr_ptr;
    logic [DEPTH_BITS-1:0]   r_rd_ptr;
    logic [DEPTH_BITS:0]     r_count;
    logic                    w_push;
    logic                    w_pop;

    // Handshakes are qualified by registered fill state only; a full buffer
    // refuses a push even when a pop happens in the same cycle.
    assign ack_to_user             = (r_count != FULL_COUNT);
    assign vld_user2interface      = (r_count != '0);
    assign din_leaf_user2interface = r_mem[r_rd_ptr];
    assign occupancy               = r_count;
    assign w_push                  = vld_user && ack_to_user;
    assign w_pop                   = vld_user2interface && ack_interface2user;

    // Storage array is not reset; its contents are meaningless while empty.
    always_ff @(posedge clk_user) begin
        if (w_push && !clear) begin
            r_mem[r_wr_ptr] <= din_user;
        end
    end

    // Pointers wrap naturally at their width; clear wins over push and pop.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_BITS'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_BITS'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (DEPTH_BITS+1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_BITS+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef LEAF_OUT_BUF_STATS_EN
    logic [31:0] r_word_count;
    logic [31:0] r_stall_count;

    assign word_count  = r_word_count;
    assign stall_count = r_stall_count;

    // Saturating counters of delivered words and downstream back-pressure cycles.
    always_ff @(posedge clk_user or negedge reset_n) begin
        if (!reset_n) begin
            r_word_count  <= '0;
            r_stall_count <= '0;
        end else if (clear) begin
            r_word_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_pop && (r_word_count != '1)) begin
                r_word_count <= r_word_count + 32'd1;
            end
            if (vld_user2interface && !ack_interface2user && (r_stall_count != '1)) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule
